// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Two-master to one-slave memory bus arbiter. Master 0 is the instruction
// bus, master 1 the data bus. Arbitration is combinational in IDLE so the
// winner's request reaches the slave with zero added latency. The grant is
// then held until the slave reports data_ok. A saturating starve counter
// forces the non-priority master to win once it has lost for STARVE_LIMIT
// cycles.

module mem_bus_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter bit DBUS_FIRST   = 1'b1,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                         clk,
    input  logic                         reset,

    // master side (index 0 = ibus, index 1 = dbus)
    input  logic [1:0]                   m_valid,
    input  logic [1:0][ADDR_W-1:0]       m_addr,
    input  logic [1:0][2:0]              m_size,
    input  logic [1:0][DATA_W/8-1:0]     m_strobe,
    input  logic [1:0][DATA_W-1:0]       m_wdata,
    output logic [1:0]                   m_addr_ok,
    output logic [1:0]                   m_data_ok,
    output logic [DATA_W-1:0]            m_rdata,

    // slave side
    output logic                         s_valid,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [2:0]                   s_size,
    output logic [DATA_W/8-1:0]          s_strobe,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic                         s_addr_ok,
    input  logic                         s_data_ok,
    input  logic [DATA_W-1:0]            s_rdata,

    // debug
    output logic [1:0]                   grant_o
);

    // Counter must hold the value STARVE_LIMIT itself.
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    // Master that wins a plain tie, and the one protected from starvation.
    localparam bit PRI_IDX = DBUS_FIRST;
    localparam bit LOW_IDX = !DBUS_FIRST;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic [CNT_W-1:0]   starve_q, starve_d;

    logic               starved;     // low-priority master is owed the next win
    logic               sel;         // IDLE arbitration winner
    logic               owner;       // BUSY owner index
    logic               src;         // master currently driving the slave bus
    logic               src_active;  // src is meaningful this cycle
    logic               low_wins;
    logic               low_waits;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------

    // Pick the IDLE winner: lone requester, else forced loser, else priority.
    always_comb begin
        starved = (starve_q == CNT_W'(STARVE_LIMIT));
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned; otherwise a latch is inferred.
        sel = PRI_IDX;
        case (m_valid)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11:   sel = starved ? LOW_IDX : PRI_IDX;
            default: sel = PRI_IDX;
        endcase
    end

    // Resolve which master owns the slave bus this cycle.
    always_comb begin
        owner      = grant_q[1];
        src        = (state_q == BUSY) ? owner : sel;
        src_active = !reset && ((state_q == BUSY) || (m_valid != 2'b00));
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State, grant and starve counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= 2'b00;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            starve_q <= starve_d;
        end
    end

    // Next state: enter BUSY unless the slave finishes in the same cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if ((m_valid != 2'b00) && !s_data_ok) begin
                    state_d = BUSY;
                    grant_d = sel ? 2'b10 : 2'b01;
                end
            end
            BUSY: begin
                // Grant is held even if the owner drops m_valid early.
                if (s_data_ok) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // Starve counter: count low-priority losses, clear when it wins.
    always_comb begin
        low_wins  = (state_q == IDLE) && (m_valid != 2'b00) && (sel == LOW_IDX);
        low_waits = m_valid[LOW_IDX] && !low_wins
                    && !((state_q == BUSY) && grant_q[LOW_IDX]);
        starve_d  = starve_q;
        if (low_wins) begin
            starve_d = '0;
        end else if (low_waits && !starved) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Outputs: forward the source master and route responses only to it.
    always_comb begin
        s_valid   = 1'b0;
        s_addr    = '0;
        s_size    = '0;
        s_strobe  = '0;
        s_wdata   = '0;
        m_addr_ok = 2'b00;
        m_data_ok = 2'b00;
        if (src_active) begin
            s_valid        = (state_q == BUSY) ? m_valid[src] : 1'b1;
            s_addr         = m_addr[src];
            s_size         = m_size[src];
            s_strobe       = m_strobe[src];
            s_wdata        = m_wdata[src];
            m_addr_ok[src] = s_addr_ok;
            m_data_ok[src] = s_data_ok;
        end
        grant_o = reset ? 2'b00 : grant_q;
        m_rdata = s_rdata;
    end

    // ------------------------------------------------------------------
    // Assertions
    // ------------------------------------------------------------------

    // BUSY always has exactly one owner, so s_valid never floats ownerless.
    a_busy_has_owner : assert property (@(posedge clk) disable iff (reset)
        (state_q == BUSY) |-> (grant_q == 2'b01 || grant_q == 2'b10));

    a_no_orphan_valid : assert property (@(posedge clk) disable iff (reset)
        !(s_valid && (state_q == BUSY) && (grant_q == 2'b00)));

    a_idle_no_grant : assert property (@(posedge clk) disable iff (reset)
        (state_q == IDLE) |-> (grant_q == 2'b00));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Directed scenarios followed by randomized traffic, all checked each cycle
// against an ownership/starvation model of the arbiter.

module tb_mem_bus_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int SW    = DW / 8;
    localparam int LIMIT = 4;
    localparam bit PR    = 1'b1;   // dbus has priority
    localparam bit NP    = 1'b0;   // ibus is protected from starvation

    logic                  clk;
    logic                  reset;
    logic [1:0]            m_valid;
    logic [1:0][AW-1:0]    m_addr;
    logic [1:0][2:0]       m_size;
    logic [1:0][SW-1:0]    m_strobe;
    logic [1:0][DW-1:0]    m_wdata;
    logic [1:0]            m_addr_ok;
    logic [1:0]            m_data_ok;
    logic [DW-1:0]         m_rdata;
    logic                  s_valid;
    logic [AW-1:0]         s_addr;
    logic [2:0]            s_size;
    logic [SW-1:0]         s_strobe;
    logic [DW-1:0]         s_wdata;
    logic                  s_addr_ok;
    logic                  s_data_ok;
    logic [DW-1:0]         s_rdata;
    logic [1:0]            grant_o;

    mem_bus_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .DBUS_FIRST   (1'b1),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_size    (m_size),
        .m_strobe  (m_strobe),
        .m_wdata   (m_wdata),
        .m_addr_ok (m_addr_ok),
        .m_data_ok (m_data_ok),
        .m_rdata   (m_rdata),
        .s_valid   (s_valid),
        .s_addr    (s_addr),
        .s_size    (s_size),
        .s_strobe  (s_strobe),
        .s_wdata   (s_wdata),
        .s_addr_ok (s_addr_ok),
        .s_data_ok (s_data_ok),
        .s_rdata   (s_rdata),
        .grant_o   (grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks who owns the bus (if anyone) and how long ibus has been losing.
    bit         own_v   = 1'b0;
    logic       own_idx = 1'b0;
    int         mcnt    = 0;

    bit         e_has;
    logic       e_idx;
    logic       e_sv;
    logic [1:0] e_aok, e_dok, e_grant;
    logic [1:0] last_dok = 2'b00;

    // observations of the last ticked cycle, for directed checks
    logic          obs_sv;
    logic [AW-1:0] obs_addr;
    logic [SW-1:0] obs_strobe;
    logic [1:0]    obs_aok, obs_dok, obs_grant;
    logic [DW-1:0] obs_rdata;

    function automatic void model_eval();
        e_has = 1'b0; e_idx = 1'b0; e_sv = 1'b0;
        e_aok = 2'b00; e_dok = 2'b00; e_grant = 2'b00;
        if (!reset) begin
            if (own_v) begin
                e_has   = 1'b1;
                e_idx   = own_idx;
                e_sv    = m_valid[own_idx];
                e_grant = own_idx ? 2'b10 : 2'b01;
            end else if (m_valid != 2'b00) begin
                e_has = 1'b1;
                e_sv  = 1'b1;
                if (m_valid == 2'b11) e_idx = (mcnt >= LIMIT) ? NP : PR;
                else                  e_idx = m_valid[1];
            end
            if (e_has) begin
                e_aok[e_idx] = s_addr_ok;
                e_dok[e_idx] = s_data_ok;
            end
        end
    endfunction

    function automatic void model_update();
        if (reset) begin
            own_v = 1'b0;
            mcnt  = 0;
        end else begin
            if (!own_v && e_has && e_idx == NP)              mcnt = 0;
            else if (m_valid[NP] && !(e_has && e_idx == NP)) mcnt = (mcnt < LIMIT) ? mcnt + 1 : LIMIT;
            if (!own_v) begin
                if (e_has && !s_data_ok) begin
                    own_v   = 1'b1;
                    own_idx = e_idx;
                end
            end else if (s_data_ok) begin
                own_v = 1'b0;
            end
        end
    endfunction

    // One clock cycle: compare outputs mid-cycle, then advance the model.
    task automatic tick();
        logic [AW-1:0] xa;
        logic [2:0]    xs;
        logic [SW-1:0] xst;
        logic [DW-1:0] xw;
        @(negedge clk);
        model_eval();
        xa = '0; xs = '0; xst = '0; xw = '0;
        if (e_has) begin
            xa = m_addr[e_idx]; xs = m_size[e_idx];
            xst = m_strobe[e_idx]; xw = m_wdata[e_idx];
        end
        check("s_valid",   64'(s_valid),   64'(e_sv));
        check("s_addr",    64'(s_addr),    64'(xa));
        check("s_size",    64'(s_size),    64'(xs));
        check("s_strobe",  64'(s_strobe),  64'(xst));
        check("s_wdata",   s_wdata,        xw);
        check("m_addr_ok", 64'(m_addr_ok), 64'(e_aok));
        check("m_data_ok", 64'(m_data_ok), 64'(e_dok));
        check("m_rdata",   m_rdata,        s_rdata);
        check("grant_o",   64'(grant_o),   64'(e_grant));
        obs_sv = s_valid; obs_addr = s_addr; obs_strobe = s_strobe;
        obs_aok = m_addr_ok; obs_dok = m_data_ok; obs_grant = grant_o; obs_rdata = m_rdata;
        last_dok = e_dok;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic quiet();
        m_valid = 2'b00; s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int arbs;
        bit won;
        bit was_idle;

        reset = 1'b1;
        m_addr = '0; m_size = '0; m_strobe = '0; m_wdata = '0;
        quiet();

        // 1. reset then idle
        tick(); tick();
        reset = 1'b0;
        tick();
        check("idle_sv",    64'(obs_sv),    64'd0);
        check("idle_grant", 64'(obs_grant), 64'd0);
        check("idle_aok",   64'(obs_aok),   64'd0);
        check("idle_dok",   64'(obs_dok),   64'd0);

        // 2. single ibus read, data_ok three cycles after the request
        m_valid = 2'b01; m_addr[0] = 32'h8000_0000; m_size[0] = 3'd3; m_strobe[0] = '0;
        s_addr_ok = 1'b1;
        tick();
        check("rd_addr", 64'(obs_addr), 64'h8000_0000);
        check("rd_aok",  64'(obs_aok),  64'h1);
        s_addr_ok = 1'b0;
        tick(); tick();
        s_data_ok = 1'b1; s_rdata = 64'h1234;
        tick();
        check("rd_dok",   64'(obs_dok),   64'h1);
        check("rd_rdata", obs_rdata,      64'h1234);
        check("rd_grant", 64'(obs_grant), 64'h1);
        quiet();
        tick();
        check("rd_grant_clr", 64'(obs_grant), 64'h0);
        check("rd_dok_once",  64'(obs_dok),   64'h0);

        // 3. simultaneous requests: dbus first, ibus with no bubble after
        m_valid = 2'b11; m_addr[1] = 32'h8000_1000; m_addr[0] = 32'h8000_2000;
        s_addr_ok = 1'b1;
        tick();
        check("sim_addr_d", 64'(obs_addr), 64'h8000_1000);
        check("sim_aok_d",  64'(obs_aok),  64'h2);
        s_addr_ok = 1'b0;
        tick();
        check("sim_grant_d", 64'(obs_grant), 64'h2);
        s_data_ok = 1'b1;
        tick();
        check("sim_dok_d", 64'(obs_dok), 64'h2);
        m_valid = 2'b01; s_data_ok = 1'b0; s_addr_ok = 1'b1;
        tick();
        check("sim_nobubble_sv", 64'(obs_sv),   64'h1);
        check("sim_addr_i",      64'(obs_addr), 64'h8000_2000);
        check("sim_aok_i",       64'(obs_aok),  64'h1);
        s_addr_ok = 1'b0; s_data_ok = 1'b1;
        tick();
        check("sim_dok_i", 64'(obs_dok), 64'h1);
        quiet();
        tick();

        // 4. starvation: dbus always requesting, one-cycle slave
        reset = 1'b1; tick(); reset = 1'b0;
        m_valid = 2'b11; m_addr[1] = 32'hD000_0000; m_addr[0] = 32'h1000_0000;
        arbs = 0; won = 1'b0;
        for (int i = 0; i < 16 && !won; i++) begin
            was_idle  = !own_v;
            s_data_ok = own_v;
            s_addr_ok = !own_v;
            if (was_idle) arbs++;
            tick();
            if (was_idle && obs_addr == 32'h1000_0000) won = 1'b1;
        end
        check("starve_won",     64'(won),        64'd1);
        check("starve_arbs_le5", 64'(arbs <= 5), 64'd1);
        s_addr_ok = 1'b0; s_data_ok = 1'b1;
        tick();
        check("starve_dok_i", 64'(obs_dok), 64'h1);
        // counter cleared by the forced win: a fresh tie goes to dbus again
        s_data_ok = 1'b0;
        tick();
        check("starve_cleared", 64'(obs_addr), 64'hD000_0000);
        m_valid = 2'b00; s_data_ok = 1'b1;
        tick();
        quiet();
        tick();

        // 5. combinational slave completes a dbus write in the request cycle
        m_valid = 2'b10; m_strobe[1] = 8'hFF; m_wdata[1] = 64'hCAFE_F00D_0BAD_BEEF;
        m_addr[1] = 32'h8000_3000;
        s_addr_ok = 1'b1; s_data_ok = 1'b1;
        tick();
        check("comb_dok",    64'(obs_dok),    64'h2);
        check("comb_strobe", 64'(obs_strobe), 64'hFF);
        m_valid = 2'b01; m_strobe[1] = '0; m_addr[0] = 32'h8000_4000; s_data_ok = 1'b0;
        tick();
        check("comb_idle_grant", 64'(obs_grant), 64'h0);
        check("comb_next_sv",    64'(obs_sv),    64'h1);
        check("comb_next_aok",   64'(obs_aok),   64'h1);
        s_addr_ok = 1'b0; s_data_ok = 1'b1;
        tick();
        quiet();
        tick();

        // 6. reset in the middle of a BUSY ibus transaction
        m_valid = 2'b01; m_addr[0] = 32'h8000_5000; s_addr_ok = 1'b1;
        tick();
        s_addr_ok = 1'b0;
        tick();
        check("rb_grant", 64'(obs_grant), 64'h1);
        reset = 1'b1;
        tick();
        check("rb_rst_sv", 64'(obs_sv), 64'h0);
        reset = 1'b0; m_valid = 2'b00;
        tick();
        check("rb_sv",    64'(obs_sv),    64'h0);
        check("rb_grant0", 64'(obs_grant), 64'h0);
        s_data_ok = 1'b1;
        tick();
        check("rb_no_route", 64'(obs_dok), 64'h0);
        quiet();
        tick();

        // 7. randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (m_valid[m] && (last_dok[m] || $urandom_range(0, 63) == 0))
                    m_valid[m] = 1'b0;
                if (!m_valid[m] && $urandom_range(0, 2) == 0) begin
                    m_valid[m]  = 1'b1;
                    m_addr[m]   = $urandom;
                    m_size[m]   = 3'($urandom_range(0, 3));
                    m_strobe[m] = ($urandom_range(0, 1) == 1) ? SW'($urandom) : '0;
                    m_wdata[m]  = {$urandom, $urandom};
                end
            end
            s_addr_ok = 1'($urandom_range(0, 1));
            s_data_ok = ($urandom_range(0, 2) == 0);
            s_rdata   = {$urandom, $urandom};
            reset     = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master to one-slave memory bus arbiter, directly downstream of the core's instruction and data bus ports.
- Master 0 is the instruction bus (fetch); master 1 is the data bus (memory stage and page-table walker).
- Merges both onto the single memory bus used by the cache/uncore.
- Holds a grant for a whole transaction and includes starvation protection for the lower-priority master.

Parameters:
- ADDR_W, 64, request address width
- DATA_W, 64, data width; strobe width is DATA_W/8
- DBUS_FIRST, 1, 1: master 1 wins simultaneous requests; 0: master 0 wins
- STARVE_LIMIT, 16, lost-arbitration cycles after which the losing master is forced to win the next arbitration

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- m_valid  input  2  per-master request valid; held until that master sees data_ok
- m_addr  input  2xADDR_W  per-master address
- m_size  input  2x3  per-master access size (log2 bytes)
- m_strobe  input  2xDATA_W/8  per-master write strobe; 0 means read
- m_wdata  input  2xDATA_W  per-master write data
- m_addr_ok  output  2  per-master address accepted
- m_data_ok  output  2  per-master transaction done
- m_rdata  output  DATA_W  read data, shared; valid only with the matching m_data_ok bit
- s_valid  output  1  downstream request valid
- s_addr  output  ADDR_W  downstream address
- s_size  output  3  downstream size
- s_strobe  output  DATA_W/8  downstream strobe
- s_wdata  output  DATA_W  downstream write data
- s_addr_ok  input  1  downstream address accepted
- s_data_ok  input  1  downstream done
- s_rdata  input  DATA_W  downstream read data
- grant_o  output  2  one-hot current owner, for debug and difftest

Behaviour:
- Clock and reset: single clock `clk`; reset is synchronous and active-high on `reset`.
- Reset: FSM goes to IDLE, grant register = 00, starve counter = 0. All s_* outputs, m_addr_ok, m_data_ok and grant_o are 0 in reset and in IDLE with no request. m_rdata is passed through unconditionally.
- State IDLE, arbitration (combinational):
  - sel = the only requesting master, if just one requests.
  - If both request: sel = the forced loser when starve counter == STARVE_LIMIT, otherwise the priority master per DBUS_FIRST.
  - The selected master's request is forwarded on s_* in the same cycle, i.e. zero added latency.
- Leaving IDLE:
  - If s_valid && !s_data_ok: next state BUSY, grant latched = sel.
  - If s_data_ok arrives in the same cycle (combinational slave): complete immediately and stay IDLE.
- State BUSY:
  - s_* = the granted master's fields, including its live m_valid.
  - s_addr_ok / s_data_ok are routed only to the granted master's bit; the other master sees 0.
  - On s_data_ok: next state IDLE, grant cleared.
  - There is no bubble between transactions: the next arbitration happens in the cycle after data_ok.
- Response routing in IDLE: responses go to sel. A non-selected master never sees addr_ok or data_ok.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, on every cycle the non-priority master has m_valid=1 and is not owner or sel.
  - Clears when that master wins arbitration.
  - A forced win also clears it.
- Protocol violations:
  - If the granted master drops m_valid before data_ok, the grant is still held until s_data_ok.
  - The request fields are not latched; the master must hold them stable.
- Simultaneous events:
  - New requests arriving while BUSY wait; no preemption.
  - data_ok and a new request in the same cycle: completion first, new arbitration next cycle.
- Reset mid-transaction: grant dropped immediately; the slave must be reset in the same cycle.
- s_valid never asserts with grant_o == 00 in BUSY; an assertion checks this.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, no requests → s_valid=0, grant_o=00, m_addr_ok=00, m_data_ok=00.
- Single ibus read: m_valid=01, addr 0x8000_0000, slave data_ok 3 cycles later with rdata 0x1234 → s_addr=0x8000_0000, m_data_ok=01 for one cycle, m_rdata=0x1234, grant_o returns to 00.
- Simultaneous requests, DBUS_FIRST=1: both valid, dbus addr 0x8000_1000 → dbus served first (grant_o=10). Ibus forwarded in the cycle after dbus data_ok, with no idle cycle.
- Starvation: dbus requests continuously, 1-cycle slave, STARVE_LIMIT=4, ibus waiting → ibus granted within 5 arbitrations; counter then reads 0.
- Combinational slave: s_addr_ok=s_data_ok=1 same cycle as the dbus write with strobe 0xFF → m_data_ok=10 that cycle; FSM stays IDLE; next request accepted the following cycle.
- Reset mid-BUSY: grant ibus, assert reset before data_ok → next cycle s_valid=0, grant_o=00, and a later data_ok is not routed to any master.
